// File: rtl/seven_sd_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture receiver.
//   - enable patterns (active-low) that select each capture lane
//   - active-low glyph table for hex digits 0-F (dp excluded)
//   - FSM state encoding and the enable->lane helper
package seven_sd_scan_capture_pkg;

  localparam logic [3:0] EN_LANE0 = 4'b0111;
  localparam logic [3:0] EN_LANE1 = 4'b1110;
  localparam logic [3:0] EN_LANE2 = 4'b1101;
  localparam logic [3:0] EN_LANE3 = 4'b1011;
  localparam logic [3:0] EN_BLANK = 4'b1111;

  // Index i holds the segment pattern for hex digit i; bit 0 = a .. bit 6 = g.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] lane;
  } lane_sel_t;

  // Lane numbering follows the driver's scan map, not the enable bit position.
  function automatic lane_sel_t lane_of(input logic [3:0] en);
    lane_sel_t sel;
    sel.hit  = 1'b1;
    sel.lane = 2'd0;
    case (en)
      EN_LANE0: sel.lane = 2'd0;
      EN_LANE1: sel.lane = 2'd1;
      EN_LANE2: sel.lane = 2'd2;
      EN_LANE3: sel.lane = 2'd3;
      default:  sel.hit  = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seven_sd_scan_capture_segment_decode.sv
// Combinational 7-segment glyph decoder.
//   seg    in  7  active-low segment pattern, [0]=a .. [6]=g
//   valid  out 1  pattern matches one of the 0-F glyphs
//   nibble out 4  decoded hex value, 0 when not a glyph
module seven_sd_segment_decode
  import seven_sd_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_sd_scan_capture.sv
// Loopback receiver for a multiplexed 7-segment drive. Samples the scanned
// bus, waits for each digit dwell to be stable, captures the segment byte into
// its lane and publishes a full 32-bit frame plus per-lane hex decode.
//   clk             in  1   system clock
//   rst             in  1   synchronous active-high reset
//   displayIn       in  8   segment bus, active-low, [7]=dp
//   enableIn        in  4   digit enables, active-low
//   capturedSignals out 32  last complete frame, lane k at [8k+7:8k]
//   frameValid      out 1   one-cycle pulse when capturedSignals updates
//   hexDigits       out 16  decoded nibble per lane
//   hexValid        out 4   lane k holds a recognised glyph
//   illegalEnable   out 1   sticky: two or more enables seen low
//   stall           out 1   no capture for TIMEOUT_CYCLES
module seven_sd_scan_capture
  import seven_sd_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2097152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  displayIn,
  input  logic [3:0]  enableIn,
  output logic [31:0] capturedSignals,
  output logic        frameValid,
  output logic [15:0] hexDigits,
  output logic [3:0]  hexValid,
  output logic        illegalEnable,
  output logic        stall
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]      sample_en, prev_en;
  logic [7:0]      sample_disp, prev_disp;
  state_t          state, state_next;
  logic [CW-1:0]   count, count_next;
  logic            capture;
  logic            changed;
  lane_sel_t       sel;
  logic            sample_illegal;
  logic [3:0][7:0] staging;
  logic [3:0]      lane_seen;
  logic [31:0]     captured_q;
  logic            frame_valid_q;
  logic [3:0][3:0] hex_q;
  logic [3:0]      hex_valid_q;
  logic            illegal_q;
  logic [TW-1:0]   stall_cnt;
  logic [3:0][3:0] dec_nibble;
  logic [3:0]      dec_valid;

  assign sel            = lane_of(sample_en);
  assign sample_illegal = (sample_en != EN_BLANK) && !sel.hit;
  assign changed        = {sample_en, sample_disp} != {prev_en, prev_disp};

  // Decode the staging bytes so the hex outputs can be registered together
  // with the frame they belong to.
  for (genvar k = 0; k < 4; k++) begin : g_dec
    seven_sd_segment_decode u_dec (
      .seg    (staging[k][6:0]),
      .valid  (dec_valid[k]),
      .nibble (dec_nibble[k])
    );
  end

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel.hit) begin
          state_next = ST_SETTLE;
          count_next = '0;
        end
      end
      ST_SETTLE: begin
        // A change on the threshold cycle takes priority over the capture.
        if (changed) begin
          count_next = '0;
          state_next = sel.hit ? ST_SETTLE : ST_IDLE;
        end else if (count == CW'(SETTLE_CYCLES - 1)) begin
          capture    = 1'b1;
          count_next = '0;
          state_next = ST_HELD;
        end else begin
          count_next = count + CW'(1);
        end
      end
      ST_HELD: begin
        if (changed) begin
          count_next = '0;
          state_next = sel.hit ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_en     <= EN_BLANK;
      sample_disp   <= '1;
      prev_en       <= EN_BLANK;
      prev_disp     <= '1;
      state         <= ST_IDLE;
      count         <= '0;
      staging       <= '1;
      lane_seen     <= '0;
      captured_q    <= '1;
      frame_valid_q <= 1'b0;
      hex_q         <= '0;
      hex_valid_q   <= '0;
      illegal_q     <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      sample_en     <= enableIn;
      sample_disp   <= displayIn;
      prev_en       <= sample_en;
      prev_disp     <= sample_disp;
      state         <= state_next;
      count         <= count_next;
      frame_valid_q <= 1'b0;

      if (sample_illegal) begin
        illegal_q <= 1'b1;
      end

      // Frame publication happens the cycle after the capture that fills
      // the last lane; a capture can never coincide with that cycle.
      if (capture) begin
        staging[sel.lane]   <= sample_disp;
        lane_seen[sel.lane] <= 1'b1;
      end else if (lane_seen == 4'hF) begin
        captured_q    <= staging;
        frame_valid_q <= 1'b1;
        hex_q         <= dec_nibble;
        hex_valid_q   <= dec_valid;
        lane_seen     <= '0;
      end

      if (capture) begin
        stall_cnt <= '0;
      end else if (stall_cnt != TW'(TIMEOUT_CYCLES)) begin
        stall_cnt <= stall_cnt + TW'(1);
      end
    end
  end

  assign capturedSignals = captured_q;
  assign frameValid      = frame_valid_q;
  assign hexDigits       = hex_q;
  assign hexValid        = hex_valid_q;
  assign illegalEnable   = illegal_q;
  assign stall           = (stall_cnt == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seven_sd_scan_capture.sv
// Directed bench for seven_sd_scan_capture: emulates the scanning driver and
// checks frames, settle boundaries, illegal enables, stall and reset.
module tb_seven_sd_scan_capture;

  localparam logic [3:0] EN0   = 4'b0111;
  localparam logic [3:0] EN1   = 4'b1110;
  localparam logic [3:0] EN2   = 4'b1101;
  localparam logic [3:0] EN3   = 4'b1011;
  localparam logic [3:0] BLANK = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  displayIn = 8'hFF;
  logic [3:0]  enableIn  = BLANK;
  logic [31:0] capturedSignals;
  logic        frameValid;
  logic [15:0] hexDigits;
  logic [3:0]  hexValid;
  logic        illegalEnable;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;

  seven_sd_scan_capture #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (300)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .displayIn       (displayIn),
    .enableIn        (enableIn),
    .capturedSignals (capturedSignals),
    .frameValid      (frameValid),
    .hexDigits       (hexDigits),
    .hexValid        (hexValid),
    .illegalEnable   (illegalEnable),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frameValid) fv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold one bus value for n clock cycles; entered and left at posedge+1.
  task automatic drive(input logic [3:0] en, input logic [7:0] d, input int n);
    enableIn  = en;
    displayIn = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cap"},   capturedSignals, 32'hFFFF_FFFF);
    check({tag, "_hex"},   32'(hexDigits), 32'h0);
    check({tag, "_hv"},    32'(hexValid), 32'h0);
    check({tag, "_fv"},    32'(frameValid), 32'h0);
    check({tag, "_ill"},   32'(illegalEnable), 32'h0);
    check({tag, "_stall"}, 32'(stall), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] d;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Frame 1 with latency measurement on the completing lane
    drive(EN0, 8'hB0, 20);
    drive(EN1, 8'hA4, 20);
    drive(EN2, 8'hF9, 20);
    check("no_frame_yet", capturedSignals, 32'hFFFF_FFFF);
    enableIn  = EN3;
    displayIn = 8'hC0;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (frameValid) begin
        lat = n;
        break;
      end
    end
    check("frame_latency", 32'(lat), 32'd19);
    @(posedge clk);
    #1;
    check("fv_one_cycle", 32'(frameValid), 32'h0);
    drive(EN3, 8'hC0, 2);
    drive(BLANK, 8'hFF, 5);
    check("f1_count", 32'(fv_count), 32'd1);
    check("f1_cap",   capturedSignals, 32'hC0F9_A4B0);
    check("f1_hex",   32'(hexDigits), 32'h0123);
    check("f1_hv",    32'(hexValid), 32'hF);

    // Lane0 overwritten before completion; lane1 dwell of 16 misses, 17 hits
    drive(EN0, 8'h40, 20);
    drive(EN0, 8'h7F, 20);
    drive(EN1, 8'h06, 16);
    drive(EN2, 8'h88, 20);
    drive(EN3, 8'h21, 20);
    drive(BLANK, 8'hFF, 5);
    check("short_dwell_no_frame", 32'(fv_count), 32'd1);
    check("short_dwell_cap", capturedSignals, 32'hC0F9_A4B0);
    drive(EN1, 8'h06, 17);
    drive(BLANK, 8'hFF, 5);
    check("f2_count", 32'(fv_count), 32'd2);
    check("f2_cap",   capturedSignals, 32'h2188_067F);
    check("f2_hex",   32'(hexDigits), 32'hDAE0);
    check("f2_hv",    32'(hexValid), 32'hE);
    check("ill_before", 32'(illegalEnable), 32'h0);

    // Illegal enable pattern for a single cycle
    drive(4'b0011, 8'h40, 1);
    drive(BLANK, 8'hFF, 3);
    check("ill_set", 32'(illegalEnable), 32'h1);
    drive(BLANK, 8'hFF, 10);
    check("ill_sticky", 32'(illegalEnable), 32'h1);

    // Lane2 dwell with display bit 3 toggling every 8 cycles: never settles
    d = 8'hF9;
    for (int i = 0; i < 12; i++) begin
      drive(EN2, d, 8);
      d[3] = ~d[3];
    end
    check("stall_low_early", 32'(stall), 32'h0);
    for (int i = 0; i < 40; i++) begin
      drive(EN2, d, 8);
      d[3] = ~d[3];
    end
    check("stall_high", 32'(stall), 32'h1);
    check("toggle_no_frame", 32'(fv_count), 32'd2);
    drive(EN2, 8'hF9, 20);
    check("stall_cleared", 32'(stall), 32'h0);

    // Reset after three lanes are captured discards the partial frame
    drive(EN0, 8'h19, 20);
    drive(EN1, 8'h19, 20);
    check("pre_rst_count", 32'(fv_count), 32'd2);
    enableIn  = BLANK;
    displayIn = 8'hFF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    drive(EN3, 8'h00, 20);
    drive(BLANK, 8'hFF, 5);
    check("post_rst_no_frame", 32'(fv_count), 32'd2);
    drive(EN0, 8'h12, 20);
    drive(EN1, 8'h02, 20);
    drive(EN2, 8'h78, 20);
    drive(BLANK, 8'hFF, 5);
    check("f3_count", 32'(fv_count), 32'd3);
    check("f3_cap",   capturedSignals, 32'h0078_0212);
    check("f3_hex",   32'(hexDigits), 32'h8765);
    check("f3_hv",    32'(hexValid), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
